stream_wrr_arbiter: RTL and testbench
=====================================

Name: stream_wrr_arbiter

Overview:
- Packet-level weighted round-robin arbiter for one slave port of the stream crossbar; successor to the per-slave round-robin arbiter.
- Selects one of S_DATA_COUNT requesting masters and holds the grant until the granted master completes a packet (handshaked beat with last).
- Adds per-master programmable weights (packets per turn), a fixed-priority mode and a zero-bubble hand-over.
- Its outputs drive the crossbar data mux and tready demux for that slave.

Parameters:
- S_DATA_COUNT, 4, number of masters (requesters); must be ≥2.
- WEIGHT_WIDTH, 4, width of each per-master weight field.
- ARB_MODE, 0, 0 = weighted round-robin; 1 = fixed priority (lowest index wins; weights ignored).
- T_ID_WIDTH, $clog2(S_DATA_COUNT), localparam, width of id_o.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  S_DATA_COUNT  per-master request (the master's tvalid toward this slave).
- weight_i  in  S_DATA_COUNT*WEIGHT_WIDTH  packets per turn; field k = bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 is treated as 1; sampled when a grant is issued.
- beat_i  in  1  slave-side handshake of the granted master's beat (tvalid & tready after the mux).
- last_i  in  1  tlast of the granted master's beat, qualified by beat_i.
- grant_o  out  S_DATA_COUNT  one-hot grant; all-zero when idle.
- id_o  out  T_ID_WIDTH  binary index of the granted master; 0 when idle.
- valid_o  out  1  a grant is active.

Behaviour:
- Reset: while rst_i = 1, at every edge grant_o = 0, id_o = 0, valid_o = 0, state = IDLE, priority pointer ptr = 0, credit = 0. Asserting reset mid-packet drops the grant on the next edge; no completion is recorded.
- State IDLE:
  - If req_i ≠ 0, the winner is chosen and registered at the edge; grant_o/id_o/valid_o become valid one cycle after the request (latency 1); go to BUSY.
  - Winner: the first set bit of req_i searching upward from ptr, wrapping modulo S_DATA_COUNT. In ARB_MODE 1 the search starts from bit 0.
  - On grant, credit is loaded with max(weight_i[winner], 1).
- State BUSY:
  - The grant is locked; changes to req_i, including deassertion by the granted master, never change the grant mid-packet.
  - beat_i without last_i: no state change.
  - beat_i & last_i (packet end), at that same edge:
    - credit is decremented.
    - If new credit > 0 and req_i[id_o] = 1, the same master keeps the grant and no rotation happens.
    - Otherwise ptr = (id_o+1) mod S_DATA_COUNT.
    - If any other master or the current one requests, the next winner is searched from the new ptr and granted at that edge (zero-bubble: new grant visible the cycle after the last beat), with credit reloaded.
    - If req_i = 0, go to IDLE; valid_o = 0 on the next cycle.
  - The request vector used at the packet-end edge is the current-cycle req_i. The finishing master is eligible only if no other master requests: in the search it comes last after wrap.
- ARB_MODE 1: credit is forced to 1. At every packet end the lowest-index requester wins; ptr stays 0.
- Counter widths: credit is WEIGHT_WIDTH bits; it never underflows, because 0 is treated as 1 at load.
- beat_i/last_i are ignored in IDLE.
- grant_o is always onehot0 and equals (1 << id_o) when valid_o = 1.

Test Plan:
- Reset/idle (S=4, mode 0): hold rst_i 3 cycles with req_i=4'b1111 → grant_o=0, valid_o=0 throughout. Release → grant_o=4'b0001, id_o=0 one cycle later.
- Rotation, all weights 1: req_i=4'b1011 constant, 1-beat packets (beat_i&last_i every cycle) → id_o sequence 0,1,3,0,1,3 with no idle cycle between grants.
- Weighting: weight=1,3,0,2 for masters 0..3, req_i=4'b1111, single-beat packets → grants 0,1,1,1,2,3,3,0… (master 2 weight 0 yields one packet).
- Lock / early drop: master 1 granted with weight 3; 5-beat packet with req_i[1] dropped after beat 2 → grant unchanged until last. At last with req_i=4'b0100 → id_o=2 next cycle.
- Fixed priority (ARB_MODE=1): req_i=4'b1110, packets complete each cycle → id_o stays 1 while req_i[1]=1. Clear bit 1 → id_o=2 after the next last.
- Reset mid-packet: rst_i pulsed on beat 2 of master 3's packet → grant_o=0 next cycle. After release with req_i=4'b1000 → id_o=3 granted from ptr=0.

Source files
------------

// File: rtl/stream_wrr_arbiter.sv
// Packet-level weighted round-robin / fixed-priority arbiter for one crossbar slave port.
// Latency: grant registered one cycle after request; zero-bubble hand-over at packet end.
// Backpressure: grant is held across stalled beats (beat_i low) until a beat with last completes.
module stream_wrr_arbiter #(
   parameter int S_DATA_COUNT = 4,
   parameter int WEIGHT_WIDTH = 4,
   parameter int ARB_MODE     = 0,
   localparam int T_ID_WIDTH  = $clog2(S_DATA_COUNT)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [S_DATA_COUNT-1:0]              req_i,
   input  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i,
   input  logic                                 beat_i,
   input  logic                                 last_i,
   output logic [S_DATA_COUNT-1:0]              grant_o,
   output logic [T_ID_WIDTH-1:0]                id_o,
   output logic                                 valid_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state_q, state_d;
   logic [T_ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [T_ID_WIDTH-1:0]   id_q, id_d;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
   logic [WEIGHT_WIDTH-1:0] credit_dec;
   logic [T_ID_WIDTH-1:0]   ptr_rot;

   // First requester at or above 'start', wrapping; the index just below start is checked last.
   function automatic logic [T_ID_WIDTH-1:0] pick(input logic [S_DATA_COUNT-1:0] req,
                                                  input logic [T_ID_WIDTH-1:0]   start);
      logic [T_ID_WIDTH-1:0] res;
      logic                  found;
      int                    idx;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < S_DATA_COUNT; i++) begin
         idx = int'(start) + i;
         if (idx >= S_DATA_COUNT) idx = idx - S_DATA_COUNT;
         if (!found && req[idx]) begin
            res   = T_ID_WIDTH'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Packets-per-turn for a new winner; a zero weight still grants one packet.
   function automatic logic [WEIGHT_WIDTH-1:0] load_credit(
         input logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weights,
         input logic [T_ID_WIDTH-1:0]                who);
      logic [WEIGHT_WIDTH-1:0] w;
      w = weights[int'(who)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (ARB_MODE == 1 || w == '0) return WEIGHT_WIDTH'(1);
      return w;
   endfunction

   // Pointer position after the current owner gives up its turn.
   always_comb begin
      credit_dec = credit_q - WEIGHT_WIDTH'(1);
      ptr_rot    = '0;
      if (ARB_MODE != 1) begin
         ptr_rot = (id_q == T_ID_WIDTH'(S_DATA_COUNT - 1)) ? '0 : id_q + T_ID_WIDTH'(1);
      end
   end

   // Next-state logic: grant on request in IDLE, hold or hand over at packet end in BUSY.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      credit_d = credit_q;
      unique case (state_q)
         IDLE: begin
            if (req_i != '0) begin
               id_d     = pick(req_i, (ARB_MODE == 1) ? '0 : ptr_q);
               credit_d = load_credit(weight_i, id_d);
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (beat_i && last_i) begin
               if (credit_dec != '0 && req_i[id_q]) begin
                  credit_d = credit_dec;
               end else begin
                  ptr_d = ptr_rot;
                  if (req_i != '0) begin
                     id_d     = pick(req_i, ptr_rot);
                     credit_d = load_credit(weight_i, id_d);
                  end else begin
                     id_d     = '0;
                     credit_d = credit_dec;
                     state_d  = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; a reset mid-packet records no completion.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         credit_q <= credit_d;
      end
   end

   // Outputs decode directly from registered state; id_q is kept at 0 while idle.
   always_comb begin
      grant_o = '0;
      valid_o = (state_q == BUSY);
      id_o    = id_q;
      if (state_q == BUSY) grant_o[id_q] = 1'b1;
   end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
module tb_stream_wrr_arbiter;

   localparam int S  = 4;
   localparam int WW = 4;

   logic          clk;
   logic          rst;
   logic [S-1:0]  req;
   logic [S*WW-1:0] weight;
   logic          beat;
   logic          last;

   logic [S-1:0]  grant0, grant1;
   logic [1:0]    id0, id1;
   logic          vld0, vld1;

   int n_tests = 0;
   int n_fail  = 0;

   stream_wrr_arbiter #(.S_DATA_COUNT(S), .WEIGHT_WIDTH(WW), .ARB_MODE(0)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .weight_i(weight),
      .beat_i(beat), .last_i(last),
      .grant_o(grant0), .id_o(id0), .valid_o(vld0)
   );

   stream_wrr_arbiter #(.S_DATA_COUNT(S), .WEIGHT_WIDTH(WW), .ARB_MODE(1)) dut_fp (
      .clk_i(clk), .rst_i(rst), .req_i(req), .weight_i(weight),
      .beat_i(beat), .last_i(last),
      .grant_o(grant1), .id_o(id1), .valid_o(vld1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model (index 0: WRR, index 1: fixed priority) ----------------
   int m_busy[2];
   int m_id[2];
   int m_cred[2];
   int m_ptr[2];

   // Winner = requester with the smallest circular distance from 'start'.
   function automatic int ref_pick(input logic [S-1:0] r, input int start);
      int best, best_d, d;
      best   = 0;
      best_d = S + 1;
      for (int k = 0; k < S; k++) begin
         if (r[k]) begin
            d = (k - start + S) % S;
            if (d < best_d) begin
               best_d = d;
               best   = k;
            end
         end
      end
      return best;
   endfunction

   function automatic int ref_weight(input int m, input logic [S*WW-1:0] w, input int who);
      int v;
      v = int'((w >> (who * WW)) & 16'hF);
      if (m == 1) return 1;
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_step(input int m, input logic r, input logic [S-1:0] q,
                             input logic [S*WW-1:0] w, input logic b, input logic l);
      if (r) begin
         m_busy[m] = 0; m_id[m] = 0; m_cred[m] = 0; m_ptr[m] = 0;
      end else if (m_busy[m] == 0) begin
         if (q != 0) begin
            m_id[m]   = ref_pick(q, (m == 1) ? 0 : m_ptr[m]);
            m_cred[m] = ref_weight(m, w, m_id[m]);
            m_busy[m] = 1;
         end
      end else if (b && l) begin
         m_cred[m] = m_cred[m] - 1;
         if (!(m_cred[m] > 0 && q[m_id[m]])) begin
            m_ptr[m] = (m == 1) ? 0 : (m_id[m] + 1) % S;
            if (q != 0) begin
               m_id[m]   = ref_pick(q, m_ptr[m]);
               m_cred[m] = ref_weight(m, w, m_id[m]);
            end else begin
               m_busy[m] = 0;
               m_id[m]   = 0;
            end
         end
      end
   endtask

   // Apply one cycle of stimulus, advance the model at the edge, sample 1 time unit later.
   task automatic drive_cycle(input logic r, input logic [S-1:0] q, input logic [S*WW-1:0] w,
                              input logic b, input logic l);
      rst = r; req = q; weight = w; beat = b; last = l;
      @(posedge clk);
      model_step(0, r, q, w, b, l);
      model_step(1, r, q, w, b, l);
      #1;
   endtask

   task automatic check(input string nm, input int row, input logic v, input logic [1:0] i,
                        input logic [S-1:0] g, input logic ev, input logic [1:0] ei);
      logic [S-1:0] eg;
      eg = ev ? (S'(1) << ei) : '0;
      n_tests++;
      if (v !== ev || i !== ei || g !== eg) begin
         n_fail++;
         $display("FAIL %s #%0d: got valid=%0d id=%0d grant=%b, expected valid=%0d id=%0d grant=%b",
                  nm, row, v, i, g, ev, ei, eg);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rst;
      logic [S-1:0]  req;
      logic [S*WW-1:0] wt;
      logic          beat;
      logic          last;
      logic          fp;
      logic          vld;
      logic [1:0]    id;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [S-1:0] q, input logic [S*WW-1:0] w,
                               input logic b, input logic l, input logic f,
                               input logic v, input logic [1:0] i);
      vec_t t;
      t.rst = r; t.req = q; t.wt = w; t.beat = b; t.last = l; t.fp = f; t.vld = v; t.id = i;
      return t;
   endfunction

   initial begin
      logic [1:0]  rot_seq[6];
      logic [1:0]  wgt_seq[8];
      logic        rr;
      logic [S-1:0] rq;
      logic [S*WW-1:0] rw;
      logic        rb, rl;

      rot_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      wgt_seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};

      // Reset holds everything idle even with all masters requesting.
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 4'b1111, 16'h1111, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 16'h1111, 0, 0, 0, 1, 0));
      // Rotation with unit weights, single-beat packets, no bubbles; beat in IDLE ignored.
      vecs.push_back(mk(1, 4'b0000, 16'h1111, 0, 0, 0, 0, 0));
      for (int k = 0; k < 6; k++) vecs.push_back(mk(0, 4'b1011, 16'h1111, 1, 1, 0, 1, rot_seq[k]));
      // Weights 1,3,0,2.
      vecs.push_back(mk(1, 4'b0000, 16'h2031, 0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 4'b1111, 16'h2031, 1, 1, 0, 1, wgt_seq[k]));
      // Lock: master 1 (weight 3) drops its request mid-packet; 5-beat packet.
      vecs.push_back(mk(1, 4'b0000, 16'h2031, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0010, 16'h2031, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 4'b0010, 16'h2031, 1, 0, 0, 1, 1));
      vecs.push_back(mk(0, 4'b0010, 16'h2031, 1, 0, 0, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 16'h2031, 1, 0, 0, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 16'h2031, 1, 0, 0, 1, 1));
      vecs.push_back(mk(0, 4'b0100, 16'h2031, 1, 1, 0, 1, 2));
      vecs.push_back(mk(0, 4'b0000, 16'h2031, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 4'b0000, 16'h2031, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0000, 16'h2031, 1, 1, 0, 0, 0));
      // Fixed priority: large weights must be ignored.
      vecs.push_back(mk(1, 4'b0000, 16'hFFFF, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'b1110, 16'hFFFF, 1, 1, 1, 1, 1));
      vecs.push_back(mk(0, 4'b1110, 16'hFFFF, 1, 1, 1, 1, 1));
      vecs.push_back(mk(0, 4'b1110, 16'hFFFF, 1, 1, 1, 1, 1));
      vecs.push_back(mk(0, 4'b1100, 16'hFFFF, 1, 1, 1, 1, 2));
      vecs.push_back(mk(0, 4'b1100, 16'hFFFF, 1, 1, 1, 1, 2));
      vecs.push_back(mk(0, 4'b1110, 16'hFFFF, 1, 1, 1, 1, 1));
      // Reset mid-packet of master 3 (ptr was 2): grant dropped, ptr back to 0.
      vecs.push_back(mk(1, 4'b0000, 16'h1111, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0010, 16'h1111, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 4'b1000, 16'h1111, 1, 1, 0, 1, 3));
      vecs.push_back(mk(0, 4'b1000, 16'h1111, 1, 0, 0, 1, 3));
      vecs.push_back(mk(1, 4'b1000, 16'h1111, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1001, 16'h1111, 0, 0, 0, 1, 0));

      for (int n = 0; n < vecs.size(); n++) begin
         drive_cycle(vecs[n].rst, vecs[n].req, vecs[n].wt, vecs[n].beat, vecs[n].last);
         if (vecs[n].fp)
            check("vec_fp", n, vld1, id1, grant1, vecs[n].vld, vecs[n].id);
         else
            check("vec_wrr", n, vld0, id0, grant0, vecs[n].vld, vecs[n].id);
      end

      // ---------------- randomized run against the model ----------------
      drive_cycle(1, '0, 16'h1111, 0, 0);
      rw = 16'h1111;
      for (int n = 0; n < 3000; n++) begin
         rr = ($urandom_range(0, 79) == 0);
         rq = S'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) rw = 16'($urandom);
         rb = 1'($urandom_range(0, 1));
         rl = ($urandom_range(0, 2) == 0);
         drive_cycle(rr, rq, rw, rb, rl);
         check("rand_wrr", n, vld0, id0, grant0, m_busy[0] != 0, 2'(m_id[0]));
         check("rand_fp",  n, vld1, id1, grant1, m_busy[1] != 0, 2'(m_id[1]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
